secuenciador_circuito_simple: RTL and testbench
===============================================

Name: secuenciador_circuito_simple

Overview:
Self-contained stimulus/capture stage wrapped around the combinational circuito_simple. Drives its inputs A, B, C through all 8 combinations under FSM control and holds each one for a settling window. Samples x, y at the end of each window into 8-bit capture vectors. Replaces hand-written `#100` stimulus with a start/busy/done handshake usable from a bench or a larger design.

Parameters:
HOLD_CYCLES, 4, clocks each vector is held; legal range 1..255; x/y sampled on the last of these
EXP_X, 8'b11010101, expected x per index {A,B,C} (bit i = vector i); x = A·B + C'; used only with CHECK_EN
EXP_Y, 8'b01010101, expected y per index; y = C'; used only with CHECK_EN

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a full 8-vector run; sampled only in IDLE or DONE
x_in  input  1  x from circuito_simple
y_in  input  1  y from circuito_simple
A  output  1  registered stimulus to circuito_simple, = idx[2]
B  output  1  registered stimulus, = idx[1]
C  output  1  registered stimulus, = idx[0]
busy  output  1  high while vectors are applied
done  output  1  high from run completion until next start or rst
x_cap  output  8  captured x, bit i = x for vector i
y_cap  output  8  captured y, bit i = y for vector i

Behaviour:
- Reset (sync, rst=1 at rising edge): state=IDLE, idx=0, hold_cnt=0, A=B=C=0, busy=0, done=0, x_cap=0, y_cap=0. rst has priority over every other input, including mid-run: the run is aborted and captures are cleared.
- States: IDLE, APPLY, DONE.
- IDLE: start=1 → APPLY. Same edge: idx=0, hold_cnt=0, busy=1, x_cap=y_cap=0.
- APPLY:
  - {A,B,C}=idx, registered.
  - hold_cnt increments each clock.
  - When hold_cnt==HOLD_CYCLES-1:
    - x_cap[idx]<=x_in, y_cap[idx]<=y_in.
    - If idx==7 → DONE (busy=0, done=1, A=B=C=0).
    - Else idx<=idx+1 and hold_cnt<=0.
  - start is ignored in APPLY.
- DONE: captures held stable. start=1 → APPLY with the same initialization as from IDLE; done drops on that edge.
- Latency: start sampled at edge k → vector 0 visible after edge k; vector n visible for cycles k+1+n·HOLD_CYCLES .. k+(n+1)·HOLD_CYCLES. done=1 after edge k+8·HOLD_CYCLES.
- Timing: circuito_simple is combinational, so x_in/y_in are valid in the same cycle as the applied vector. No extra pipeline stage.
- Widths: idx 3 bits, no wrap (exit at 7). hold_cnt 8 bits.
- HOLD_CYCLES=1: sample on every APPLY cycle, one vector per clock.

Optional Feature:
Macro CHECK_EN.
- Defined:
  - Adds output err_count (4 bits, 0..8) and output pass (1 bit).
  - At each sample, err_count increments if x_in!=EXP_X[idx] or y_in!=EXP_Y[idx]. Counts once per vector, even if both bits mismatch.
  - err_count clears on rst and on run start.
  - pass = done & (err_count==0), registered, reset 0.
- Not defined: neither port nor the comparison logic exists. Behaviour is otherwise identical.

Test Plan:
1. rst for 2 clks, start pulse 1 clk, HOLD_CYCLES=4, real circuito_simple → x_cap=8'hD5, y_cap=8'h55, done=1 exactly 32 edges after start sample, busy=0.
2. Same run, monitor A,B,C → sequence 000,001,…,111, each held exactly 4 cycles, then 000 with done=1.
3. start held high throughout the run → single run only, no restart until DONE. Pulse start in DONE → done=0, captures clear to 0, new run completes with the same values.
4. rst asserted while idx=3 → after that edge A=B=C=0, busy=0, done=0, x_cap=y_cap=0, state IDLE. Subsequent start runs normally.
5. CHECK_EN defined, y_in forced to 0 → err_count=4 (even vectors), pass=0. Correct circuit → err_count=0, pass=1.
6. HOLD_CYCLES=1 → done after 8 edges from start sample, each vector visible for exactly 1 cycle, captures as in scenario 1.

Source files
------------

// File: rtl/secuenciador_circuito_simple.sv
// Stimulus/capture sequencer for circuito_simple: walks {A,B,C} through 0..7, holds each vector
// HOLD_CYCLES clocks and captures x/y on the last one. Optional self-check under `CHECK_EN.
module secuenciador_circuito_simple #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [7:0]  EXP_X       = 8'b11010101,
  parameter logic [7:0]  EXP_Y       = 8'b01010101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       x_in,
  input  logic       y_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_cap,
  output logic [7:0] y_cap
`ifdef CHECK_EN
  ,
  output logic [3:0] err_count,
  output logic       pass
`endif
);

  typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] x_cap_q, x_cap_d;
  logic [7:0] y_cap_q, y_cap_d;

  logic hold_last;
  logic run_start;

  assign hold_last = (hold_q == HoldLast);
  // start is only honoured outside APPLY
  assign run_start = (state_q != StApply) && start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    abc_d   = abc_q;
    x_cap_d = x_cap_q;
    y_cap_d = y_cap_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (run_start) begin
          state_d = StApply;
          idx_d   = 3'd0;
          hold_d  = 8'd0;
          abc_d   = 3'd0;
          x_cap_d = 8'd0;
          y_cap_d = 8'd0;
        end
      end
      StApply: begin
        hold_d = hold_q + 8'd1;
        if (hold_last) begin
          x_cap_d[idx_q] = x_in;
          y_cap_d[idx_q] = y_in;
          hold_d         = 8'd0;
          if (idx_q == 3'd7) begin
            state_d = StDone;
            abc_d   = 3'd0;
          end else begin
            // stimulus register moves with idx so the new vector appears on the same edge
            idx_d = idx_q + 3'd1;
            abc_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      hold_q  <= 8'd0;
      abc_q   <= 3'd0;
      x_cap_q <= 8'd0;
      y_cap_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      abc_q   <= abc_d;
      x_cap_q <= x_cap_d;
      y_cap_q <= y_cap_d;
    end
  end

  assign {A, B, C} = abc_q;
  assign busy      = (state_q == StApply);
  assign done      = (state_q == StDone);
  assign x_cap     = x_cap_q;
  assign y_cap     = y_cap_q;

`ifdef CHECK_EN
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       sample;

  assign sample = (state_q == StApply) && hold_last;

  always_comb begin
    err_d = err_q;
    if (run_start) begin
      err_d = 4'd0;
    end else if (sample && ((x_in != EXP_X[idx_q]) || (y_in != EXP_Y[idx_q]))) begin
      err_d = err_q + 4'd1;
    end
    // registered so pass rises on the same edge as done
    pass_d = (state_d == StDone) && (err_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 4'd0;
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      pass_q <= pass_d;
    end
  end

  assign err_count = err_q;
  assign pass      = pass_q;
`else
  logic unused_exp;
  assign unused_exp = ^{EXP_X, EXP_Y};
`endif

endmodule

// File: tb/tb_secuenciador_circuito_simple.sv
// Bench for secuenciador_circuito_simple: two instances (HOLD_CYCLES 4 and 1) driving a model of
// circuito_simple with random per-vector fault masks; build with +define+CHECK_EN for self-check.
module tb_secuenciador_circuito_simple;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] a_o, b_o, c_o, busy, done;
  logic [7:0] x_cap [2];
  logic [7:0] y_cap [2];
  logic [7:0] xmask [2];
  logic [7:0] ymask [2];
  wire  [1:0] x_in, y_in;
`ifdef CHECK_EN
  logic [3:0] err_count [2];
  logic [1:0] pass;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [2:0] vec;
    assign vec = {a_o[g], b_o[g], c_o[g]};
    // circuito_simple (x = A&B | ~C, y = ~C) with optional fault injection per vector
    assign x_in[g] = ((a_o[g] & b_o[g]) | ~c_o[g]) ^ xmask[g][vec];
    assign y_in[g] = ~c_o[g] ^ ymask[g][vec];

    secuenciador_circuito_simple #(
      .HOLD_CYCLES(g == 0 ? 4 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .x_in     (x_in[g]),
      .y_in     (y_in[g]),
      .A        (a_o[g]),
      .B        (b_o[g]),
      .C        (c_o[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .x_cap    (x_cap[g]),
      .y_cap    (y_cap[g])
`ifdef CHECK_EN
      ,
      .err_count(err_count[g]),
      .pass     (pass[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] gold_x(input int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (((i >> 2) & (i >> 1) & 1) | (~i & 1)) != 0;
    return v ^ xmask[d];
  endfunction

  function automatic logic [7:0] gold_y(input int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (~i & 1) != 0;
    return v ^ ymask[d];
  endfunction

  task automatic check_idle(input int d, input string tag);
    check_eq({tag, "_state"}, {busy[d], done[d], a_o[d], b_o[d], c_o[d]}, 0);
    check_eq({tag, "_caps"}, {x_cap[d], y_cap[d]}, 0);
  endtask

  task automatic run(input int d, input bit hold_start);
    int h;
    int nerr;
    logic [7:0] ex, ey;
    h = hold_of(d);
    ex = gold_x(d);
    ey = gold_y(d);
    nerr = 0;
    for (int i = 0; i < 8; i++) if (xmask[d][i] || ymask[d][i]) nerr++;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    if (!hold_start) start[d] = 1'b0;
    check_eq("caps_cleared", {x_cap[d], y_cap[d]}, 0);
    for (int c = 0; c < 8 * h; c++) begin
      if (c > 0) @(negedge clk);
      check_eq("apply_vec", {busy[d], done[d], a_o[d], b_o[d], c_o[d]}, {2'b10, 3'(c / h)});
    end
    @(negedge clk);
    check_eq("done_state", {busy[d], done[d], a_o[d], b_o[d], c_o[d]}, 5'b01000);
    start[d] = 1'b0;
    check_eq("x_cap", x_cap[d], ex);
    check_eq("y_cap", y_cap[d], ey);
`ifdef CHECK_EN
    check_eq("err_count", err_count[d], nerr);
    check_eq("pass", pass[d], nerr == 0);
`endif
    @(negedge clk);
    check_eq("done_hold", {busy[d], done[d], x_cap[d], y_cap[d]}, {2'b01, ex, ey});
  endtask

  initial begin
    rst   = 1'b1;
    start = 2'b00;
    for (int d = 0; d < 2; d++) begin
      xmask[d] = 8'h00;
      ymask[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    run(0, 1'b0);
    run(1, 1'b0);
    run(0, 1'b1);
    run(1, 1'b1);

    // y stuck at 0: every even vector is wrong
    ymask[0] = 8'h55;
    run(0, 1'b0);
    ymask[0] = 8'h00;

    for (int r = 0; r < 8; r++) begin
      int d;
      d = int'($urandom_range(0, 1));
      xmask[d] = 8'($urandom);
      ymask[d] = 8'($urandom);
      run(d, 1'($urandom_range(0, 1)));
    end

    // abort a run while vector 3 is applied
    xmask[0] = 8'h00;
    ymask[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("mid_vec", {busy[0], a_o[0], b_o[0], c_o[0]}, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "abort0");
    check_idle(1, "abort1");
    @(negedge clk);
    check_idle(0, "abort_idle");
    run(0, 1'b0);
    run(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
